// File: rtl/pkt_encoder.sv
// pkt_encoder: serialises one USB token, data or handshake packet per request into a raw bit
// stream (SYNC, PID/~PID, payload, inverted CRC MSB first), then an EOP strobe and pkt_sent.
module pkt_encoder #(
  parameter logic [7:0] SYNC_PATTERN = 8'b1000_0000,
  parameter int         DATA_BITS    = 64
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 encode,
  input  logic                 kill,
  input  logic [3:0]           pid,
  input  logic [6:0]           addr,
  input  logic [3:0]           endp,
  input  logic [DATA_BITS-1:0] data,
  input  logic [4:0]           crc_type,
  input  logic                 bit_ready,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 eop,
  output logic                 pkt_sent,
  output logic                 busy
);

  // state | meaning
  // IDLE  | no packet in flight, waiting for encode
  // SYNC  | sending the 8 SYNC bits
  // PID   | sending pid then ~pid
  // TOKEN | sending addr then endp, CRC5 accumulating
  // DATA  | sending the data payload, CRC16 accumulating
  // CRC   | sending the inverted CRC remainder, MSB first
  // EOP   | one cycle end-of-packet strobe, no valid bit
  // DONE  | one cycle pkt_sent pulse
  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_TOKEN, ST_DATA, ST_CRC, ST_EOP, ST_DONE
  } state_t;

  typedef enum logic [1:0] {KIND_HS, KIND_TOK, KIND_DAT} kind_t;

  localparam int SR_W = 16 + DATA_BITS;

  state_t               state_q, state_d;
  kind_t                kind_q, kind_d;
  kind_t                req_kind;
  logic [6:0]           cnt_q, cnt_d;
  logic [SR_W-1:0]      shreg_q, shreg_d;
  logic [4:0]           crc5_q, crc5_d, crc5_nxt;
  logic [15:0]          crc16_q, crc16_d, crc16_nxt;
  logic [DATA_BITS-1:0] payload;
  logic                 accept, last, start;

  assign bit_valid = state_q inside {ST_SYNC, ST_PID, ST_TOKEN, ST_DATA, ST_CRC};
  assign bit_out   = bit_valid & shreg_q[0];
  assign eop       = (state_q == ST_EOP);
  assign pkt_sent  = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  assign accept = bit_valid & bit_ready;
  assign last   = accept & (cnt_q == 7'd0);
  assign start  = encode & ((state_q == ST_IDLE) | kill);

  always_comb begin
    req_kind = KIND_HS;
    if (crc_type == 5'd5)       req_kind = KIND_TOK;
    else if (crc_type == 5'd16) req_kind = KIND_DAT;
  end

  assign payload = (req_kind == KIND_TOK) ? DATA_BITS'({endp, addr}) : data;

  // Serial CRC, fed LSB-first with the bit currently on bit_out
  assign crc5_nxt  = {crc5_q[3:0], 1'b0} ^ ({5{shreg_q[0] ^ crc5_q[4]}} & 5'h05);
  assign crc16_nxt = {crc16_q[14:0], 1'b0} ^ ({16{shreg_q[0] ^ crc16_q[15]}} & 16'h8005);

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;

    if (start) begin
      state_d = ST_SYNC;
      kind_d  = req_kind;
      cnt_d   = 7'd7;
      shreg_d = {payload, ~pid, pid, SYNC_PATTERN};
      crc5_d  = '1;
      crc16_d = '1;
    end else if (kill) begin
      state_d = ST_IDLE;
    end else begin
      if (accept) begin
        shreg_d = shreg_q >> 1;
        if (cnt_q != 7'd0) cnt_d = cnt_q - 7'd1;
      end
      if (accept && state_q == ST_TOKEN) crc5_d = crc5_nxt;
      if (accept && state_q == ST_DATA)  crc16_d = crc16_nxt;

      case (state_q)
        ST_SYNC: begin
          if (last) begin
            state_d = ST_PID;
            cnt_d   = 7'd7;
          end
        end
        ST_PID: begin
          if (last) begin
            case (kind_q)
              KIND_TOK: begin
                state_d = ST_TOKEN;
                cnt_d   = 7'd10;
              end
              KIND_DAT: begin
                state_d = ST_DATA;
                cnt_d   = 7'(DATA_BITS - 1);
              end
              default: state_d = ST_EOP;
            endcase
          end
        end
        ST_TOKEN: begin
          if (last) begin
            state_d = ST_CRC;
            cnt_d   = 7'd4;
            shreg_d = '0;
            for (int i = 0; i < 5; i++) shreg_d[i] = ~crc5_nxt[4-i];
          end
        end
        ST_DATA: begin
          if (last) begin
            state_d = ST_CRC;
            cnt_d   = 7'd15;
            shreg_d = '0;
            for (int i = 0; i < 16; i++) shreg_d[i] = ~crc16_nxt[15-i];
          end
        end
        ST_CRC:  if (last) state_d = ST_EOP;
        ST_EOP:  state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_HS;
      cnt_q   <= '0;
      shreg_q <= '0;
      crc5_q  <= '1;
      crc16_q <= '1;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

endmodule

// File: tb/tb_pkt_encoder.sv
// Directed bench for pkt_encoder: table of packets with hand-set lengths plus corner sequences
// for backpressure, kill, kill+encode, reset and ignored encode.
module tb_pkt_encoder;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        encode, kill;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data;
  logic [4:0]  crc_type;
  logic        bit_ready;
  logic        bit_out, bit_valid, eop, pkt_sent, busy;

  int checks = 0;
  int errors = 0;

  pkt_encoder dut (
    .clk(clk), .rst_b(rst_b), .encode(encode), .kill(kill), .pid(pid), .addr(addr),
    .endp(endp), .data(data), .crc_type(crc_type), .bit_ready(bit_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .eop(eop), .pkt_sent(pkt_sent), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic [4:0]  ctype;
    int          stall;
    int          exp_len;
  } vec_t;

  vec_t vecs[7];

  logic [127:0] cap_bits, ref_bits;
  int cap_n, cap_eop_cyc, cap_sent_cyc, cap_stall, cap_eop_n, cap_sent_n, cap_unstable;
  logic cap_vak, cap_busy_s;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] exp_prefix(input logic [3:0] p, input logic [6:0] a,
                                             input logic [3:0] e, input logic [63:0] d,
                                             input logic [4:0] t);
    logic [95:0] v;
    v = '0;
    v[7] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v[8+i]  = p[i];
      v[12+i] = ~p[i];
    end
    if (t == 5'd5) begin
      for (int i = 0; i < 7; i++) v[16+i] = a[i];
      for (int i = 0; i < 4; i++) v[23+i] = e[i];
    end else if (t == 5'd16) begin
      for (int i = 0; i < 64; i++) v[16+i] = d[i];
    end
    return v;
  endfunction

  // Running the CRC over payload plus transmitted CRC must leave the USB residual
  function automatic logic [4:0] resid5(input logic [127:0] b);
    logic [4:0] r;
    logic fb;
    r = 5'h1F;
    for (int i = 16; i < 32; i++) begin
      fb = b[i] ^ r[4];
      r = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return r;
  endfunction

  function automatic logic [15:0] resid16(input logic [127:0] b);
    logic [15:0] r;
    logic fb;
    r = 16'hFFFF;
    for (int i = 16; i < 96; i++) begin
      fb = b[i] ^ r[15];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return r;
  endfunction

  task automatic drive_req(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] d, input logic [4:0] t, input logic k);
    pid = p; addr = a; endp = e; data = d; crc_type = t;
    encode = 1'b1; kill = k;
    @(posedge clk);
    @(negedge clk);
    encode = 1'b0; kill = 1'b0;
  endtask

  // Entered at the negedge of cycle 1 after the encode edge
  task automatic capture(input int stall_en, input int kill_at, input int ign_at, input int budget);
    logic v, b, e, s, bz, rdy, prev_stalled, prev_bit;
    cap_bits = '0; cap_n = 0; cap_eop_cyc = -1; cap_sent_cyc = -1; cap_stall = 0;
    cap_eop_n = 0; cap_sent_n = 0; cap_unstable = 0; cap_vak = 1'bx; cap_busy_s = 1'b0;
    prev_stalled = 1'b0; prev_bit = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc > 1) @(negedge clk);
      v = bit_valid; b = bit_out; e = eop; s = pkt_sent; bz = busy;
      if (kill_at > 0 && cyc == kill_at + 1) cap_vak = v;
      kill = (kill_at > 0 && cyc == kill_at);
      encode = (ign_at > 0 && cyc == ign_at);
      if (encode) begin
        pid = 4'b0010; crc_type = 5'd0;
      end
      rdy = (stall_en != 0) ? ((cyc % 3) != 0) : 1'b1;
      bit_ready = rdy;
      if (prev_stalled && v && (b != prev_bit)) cap_unstable++;
      prev_stalled = v && !rdy;
      prev_bit = b;
      if (v && !rdy) cap_stall++;
      if (v && rdy && cap_n < 128) begin
        cap_bits[cap_n] = b;
        cap_n++;
      end
      if (e) begin
        cap_eop_n++;
        cap_eop_cyc = cyc;
      end
      if (s) begin
        cap_sent_n++;
        cap_sent_cyc = cyc;
        cap_busy_s = bz;
        if (kill_at == 0) break;
      end
    end
    kill = 1'b0; encode = 1'b0; bit_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input logic [3:0] p, input logic [6:0] a,
                              input logic [3:0] e, input logic [63:0] d, input logic [4:0] t,
                              input int exp_len);
    logic [95:0] ex;
    int plen, mism;
    ex = exp_prefix(p, a, e, d, t);
    plen = (t == 5'd5) ? 27 : (t == 5'd16) ? 80 : 16;
    mism = 0;
    for (int i = 0; i < plen; i++) if (cap_bits[i] !== ex[i]) mism++;
    chk({tag, " len"}, 128'(cap_n), 128'(exp_len));
    chk({tag, " header/payload bit errors"}, 128'(mism), 128'(0));
    if (t == 5'd5)  chk({tag, " crc5 residual"}, 128'(resid5(cap_bits)), 128'(5'h0C));
    if (t == 5'd16) chk({tag, " crc16 residual"}, 128'(resid16(cap_bits)), 128'(16'h800D));
    chk({tag, " eop count"}, 128'(cap_eop_n), 128'(1));
    chk({tag, " pkt_sent count"}, 128'(cap_sent_n), 128'(1));
    chk({tag, " eop cycle"}, 128'(cap_eop_cyc), 128'(exp_len + 1 + cap_stall));
    chk({tag, " pkt_sent cycle"}, 128'(cap_sent_cyc), 128'(exp_len + 2 + cap_stall));
    chk({tag, " busy at pkt_sent"}, 128'(cap_busy_s), 128'(1));
    chk({tag, " bit_out stable in stall"}, 128'(cap_unstable), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev;
    vecs[0] = '{4'b1001, 7'd5,    4'd4,   64'h0,                   5'd5,  0, 32};
    vecs[1] = '{4'b0011, 7'd0,    4'd0,   64'h0123_4567_89AB_CDEF, 5'd16, 0, 96};
    vecs[2] = '{4'b0010, 7'd0,    4'd0,   64'h0,                   5'd0,  0, 16};
    vecs[3] = '{4'b1011, 7'd0,    4'd0,   64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 0, 96};
    vecs[4] = '{4'b0001, 7'h7F,   4'hF,   64'h0,                   5'd5,  0, 32};
    vecs[5] = '{4'b1010, 7'd3,    4'd2,   64'h55,                  5'd7,  0, 16};
    vecs[6] = '{4'b0011, 7'd0,    4'd0,   64'h0123_4567_89AB_CDEF, 5'd16, 1, 96};

    rst_b = 1'b0; encode = 1'b0; kill = 1'b0; pid = '0; addr = '0; endp = '0;
    data = '0; crc_type = '0; bit_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 128'({bit_out, bit_valid, eop, pkt_sent, busy}), 128'(0));
    rst_b = 1'b1;
    @(negedge clk);

    // kill alone in IDLE does nothing
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("idle kill outputs", 128'({bit_out, bit_valid, eop, pkt_sent, busy}), 128'(0));

    for (int i = 0; i < 7; i++) begin
      drive_req(vecs[i].pid, vecs[i].addr, vecs[i].endp, vecs[i].data, vecs[i].ctype, 1'b0);
      capture(vecs[i].stall, 0, 0, 300);
      check_stream($sformatf("vec%0d", i), vecs[i].pid, vecs[i].addr, vecs[i].endp,
                   vecs[i].data, vecs[i].ctype, vecs[i].exp_len);
      if (i == 1) ref_bits = cap_bits;
      if (vecs[i].stall != 0) begin
        chk("stall cycles seen", 128'(cap_stall > 0), 128'(1));
        chk("stalled stream equals unstalled", cap_bits, ref_bits);
      end
      @(negedge clk);
      chk($sformatf("vec%0d idle after", i), 128'({busy, bit_valid, eop, pkt_sent}), 128'(0));
    end

    // kill alone mid data packet
    drive_req(4'b0011, 7'd0, 4'd0, 64'hDEAD_BEEF_0000_1111, 5'd16, 1'b0);
    capture(0, 40, 0, 150);
    chk("kill bit_valid next", 128'(cap_vak), 128'(0));
    chk("kill eop count", 128'(cap_eop_n), 128'(0));
    chk("kill pkt_sent count", 128'(cap_sent_n), 128'(0));
    chk("kill busy after", 128'(busy), 128'(0));

    // kill+encode at bit 20 of a token restarts with the new request
    drive_req(4'b1001, 7'd5, 4'd4, 64'h0, 5'd5, 1'b0);
    ev = 0;
    for (int c = 1; c < 20; c++) begin
      if (pkt_sent || eop) ev++;
      @(negedge clk);
    end
    drive_req(4'b0001, 7'h7F, 4'hF, 64'h0, 5'd5, 1'b1);
    chk("kill+encode sync bit0", 128'({bit_valid, bit_out, busy}), 128'(3'b101));
    capture(0, 0, 0, 300);
    chk("kill+encode old packet events", 128'(ev), 128'(0));
    check_stream("kill+encode", 4'b0001, 7'h7F, 4'hF, 64'h0, 5'd5, 32);
    @(negedge clk);

    // reset mid token
    drive_req(4'b1001, 7'd5, 4'd4, 64'h0, 5'd5, 1'b0);
    repeat (9) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("mid-packet reset outputs", 128'({bit_out, bit_valid, eop, pkt_sent, busy}), 128'(0));
    rst_b = 1'b1;
    ev = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (eop || pkt_sent || busy || bit_valid) ev++;
    end
    chk("after reset quiet", 128'(ev), 128'(0));

    // encode while busy without kill is ignored
    drive_req(4'b1001, 7'd5, 4'd4, 64'h0, 5'd5, 1'b0);
    capture(0, 0, 5, 300);
    check_stream("ignored encode", 4'b1001, 7'd5, 4'd4, 64'h0, 5'd5, 32);
    @(negedge clk);
    chk("ignored encode idle after", 128'({busy, bit_valid}), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
